// File: rtl/apb_regbank_completer.sv
// APB4 completer with pstrb/pslverr, programmable wait states and a bank of RW/RO registers.
// Latency: pready in T1+WAIT_STATES; wait states stretch the access phase, and psel dropping early aborts it.
module apb_regbank_completer #(
    parameter int                  ADDR_WIDTH  = 32,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFS) - 1);
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [3:0]            CNT_LAST   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   dec_idx_full;
    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_in_range;
    logic                    dec_ro;
    logic                    dec_err;

    // Decode of the bus address as presented in the setup cycle.
    always_comb begin
        dec_idx_full = paddr >> OFS;
        dec_in_range = dec_idx_full < NUM_REGS_A;
        dec_idx      = dec_idx_full[IDX_W-1:0];
        dec_ro       = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec_in_range && dec_idx == IDX_W'(i)) dec_ro = RO_MASK[i];
        end
        dec_err = (|(paddr & ALIGN_MASK)) | ~dec_in_range | (pwrite & dec_ro);
    end

    logic                  fire_done;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_write;
    logic                  cur_err;
    logic [DATA_WIDTH-1:0] rd_lane;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        regs_d     = regs_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        wr_pulse_d = '0;
        fire_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    idx_d   = dec_idx;
                    write_d = pwrite;
                    err_d   = dec_err;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    cnt_d   = 4'd0;
                    if (WAIT_STATES == 0) begin
                        state_d   = S_DONE;
                        fire_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (penable) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_DONE;
                        fire_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (psel && penable && pready_q && write_q && !err_q) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            wr_pulse_d[i] = 1'b1;
                            for (int b = 0; b < STRB_W; b++) begin
                                if (strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // With no wait states the response is built straight from the live decode.
        cur_idx   = (state_q == S_IDLE) ? dec_idx : idx_q;
        cur_write = (state_q == S_IDLE) ? pwrite  : write_q;
        cur_err   = (state_q == S_IDLE) ? dec_err : err_q;
        rd_lane   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_idx == IDX_W'(i))
                rd_lane = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        end
        if (fire_done) begin
            pready_d  = 1'b1;
            pslverr_d = cur_err;
            if (!cur_write && !cur_err) prdata_d = rd_lane;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign prdata   = prdata_q;
    assign wr_pulse = wr_pulse_q;

    // Read-only lanes are sourced from hw_status, so they present zero to core logic.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
    end

endmodule
